// File: rtl/sonar_frame_tx.sv
// sonar_frame_tx
// Sequences one latched BCD angle and one BCD distance reading into an ASCII
// frame: angle digits, SEP, distance digits, TERM. Characters are handed to
// the serial transmitter one at a time over the partida_serial/pronto_serial
// handshake.
//
// Ports
//   clock          in   system clock
//   reset          in   synchronous active-high reset
//   enviar         in   frame request, acted on only while idle
//   angulo         in   BCD angle, MSD in the top nibble
//   distancia      in   BCD distance, MSD in the top nibble
//   suprime_zeros  in   1 = blank leading zeros (sampled at frame load)
//   pronto_serial  in   character-done pulse from the transmitter
//   partida_serial out  one-cycle start pulse to the transmitter
//   dados_ascii    out  character presented to the transmitter
//   ocupado        out  frame in progress
//   pronto         out  one-cycle frame-complete pulse
//   db_estado      out  current state code (debug)
module sonar_frame_tx #(
  parameter int         DIGITS_A = 3,
  parameter int         DIGITS_D = 3,
  parameter logic [6:0] SEP      = 7'h2C,
  parameter logic [6:0] TERM     = 7'h23
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enviar,
  input  logic [4*DIGITS_A-1:0] angulo,
  input  logic [4*DIGITS_D-1:0] distancia,
  input  logic                  suprime_zeros,
  input  logic                  pronto_serial,
  output logic                  partida_serial,
  output logic [6:0]            dados_ascii,
  output logic                  ocupado,
  output logic                  pronto,
  output logic [3:0]            db_estado
);

  localparam int L  = DIGITS_A + DIGITS_D + 2;
  localparam int IW = $clog2(L);

  typedef enum logic [3:0] {
    OCIOSO  = 4'd0,
    CARREGA = 4'd1,
    ENVIA   = 4'd2,
    ESPERA  = 4'd3,
    PROXIMO = 4'd4,
    FIM     = 4'd5
  } state_t;

  state_t                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [6:0]              dados_q, dados_d;
  logic [4*DIGITS_A-1:0]   ang_q;
  logic [4*DIGITS_D-1:0]   dist_q;
  logic                    sz_q;

  // Encode digit 'pos' (0 = most significant) of an n-digit field held
  // right-aligned in f. A zero is blanked only if every more significant
  // digit is also zero; the last digit is never blanked, and any nibble
  // above 9 counts as non-zero.
  function automatic logic [6:0] enc_digit(input logic [15:0] f, input int n,
                                           input int pos, input logic sz);
    logic [3:0] nib;
    logic       lead_zero;
    nib       = 4'(f >> (4 * (n - 1 - pos)));
    lead_zero = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k <= pos) begin
        if (4'(f >> (4 * (n - 1 - k))) != 4'd0) lead_zero = 1'b0;
      end
    end
    if (sz && (pos != n - 1) && lead_zero) return 7'h20;
    else if (nib <= 4'd9)                  return {3'b011, nib};
    else                                   return 7'h3F;
  endfunction

  // Character at frame position i for the given fields.
  function automatic logic [6:0] char_at(input int i, input logic [15:0] a,
                                         input logic [15:0] d, input logic sz);
    if (i < DIGITS_A)      return enc_digit(a, DIGITS_A, i, sz);
    else if (i == DIGITS_A) return SEP;
    else if (i < L - 1)    return enc_digit(d, DIGITS_D, i - DIGITS_A - 1, sz);
    else                   return TERM;
  endfunction

  // Next-state, index and character selection.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dados_d = dados_q;
    case (state_q)
      OCIOSO: begin
        if (enviar) state_d = CARREGA;
        else        state_d = OCIOSO;
      end
      CARREGA: begin
        // Fields are being latched this cycle, so character 0 comes
        // straight from the inputs.
        idx_d   = '0;
        dados_d = char_at(0, 16'(angulo), 16'(distancia), suprime_zeros);
        state_d = ENVIA;
      end
      ENVIA: state_d = ESPERA;
      ESPERA: begin
        if (pronto_serial) state_d = PROXIMO;
        else               state_d = ESPERA;
      end
      PROXIMO: begin
        if (idx_q == IW'(L - 1)) begin
          state_d = FIM;
        end else begin
          idx_d   = idx_q + IW'(1);
          dados_d = char_at(int'(idx_q) + 1, 16'(ang_q), 16'(dist_q), sz_q);
          state_d = ENVIA;
        end
      end
      FIM:     state_d = OCIOSO;
      default: state_d = OCIOSO;
    endcase
  end

  // State, index, character and latched-field registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= OCIOSO;
      idx_q   <= '0;
      dados_q <= 7'h00;
      ang_q   <= '0;
      dist_q  <= '0;
      sz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dados_q <= dados_d;
      if (state_q == CARREGA) begin
        ang_q  <= angulo;
        dist_q <= distancia;
        sz_q   <= suprime_zeros;
      end
    end
  end

  // Moore outputs decoded from the state register.
  assign partida_serial = (state_q == ENVIA);
  assign pronto         = (state_q == FIM);
  assign ocupado        = (state_q != OCIOSO);
  assign db_estado      = state_q;
  assign dados_ascii    = dados_q;

endmodule

// File: tb/tb_sonar_frame_tx.sv
module tb_sonar_frame_tx;

  localparam int W = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        enviar [2];
  logic        sz     [2];
  logic        pronto_s0, pronto_s1;
  logic        stray0;
  logic [11:0] ang0, dist0;
  logic [7:0]  ang1;
  logic [15:0] dist1;

  logic        partida [2];
  logic [6:0]  dados   [2];
  logic        ocupado [2];
  logic        pronto  [2];
  logic [3:0]  db      [2];

  logic [6:0]  exp_q0 [$];
  logic [6:0]  exp_q1 [$];
  int          fchars  [2];
  int          pronto_cnt [2];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  sonar_frame_tx u0 (
    .clock(clk), .reset(reset), .enviar(enviar[0]), .angulo(ang0),
    .distancia(dist0), .suprime_zeros(sz[0]), .pronto_serial(pronto_s0),
    .partida_serial(partida[0]), .dados_ascii(dados[0]), .ocupado(ocupado[0]),
    .pronto(pronto[0]), .db_estado(db[0])
  );

  sonar_frame_tx #(.DIGITS_A(2), .DIGITS_D(4)) u1 (
    .clock(clk), .reset(reset), .enviar(enviar[1]), .angulo(ang1),
    .distancia(dist1), .suprime_zeros(sz[1]), .pronto_serial(pronto_s1),
    .partida_serial(partida[1]), .dados_ascii(dados[1]), .ocupado(ocupado[1]),
    .pronto(pronto[1]), .db_estado(db[1])
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  // Transmitter model for u0: optional stray pronto during ENVIA, then a
  // real pronto W cycles after partida.
  initial begin
    pronto_s0 = 1'b0;
    forever begin
      @(negedge clk);
      if (partida[0]) begin
        if (stray0) pronto_s0 = 1'b1;
        @(negedge clk);
        pronto_s0 = 1'b0;
        repeat (W - 1) @(negedge clk);
        pronto_s0 = 1'b1;
        @(negedge clk);
        pronto_s0 = 1'b0;
      end
    end
  end

  // Transmitter model for u1.
  initial begin
    pronto_s1 = 1'b0;
    forever begin
      @(negedge clk);
      if (partida[1]) begin
        @(negedge clk);
        repeat (W - 1) @(negedge clk);
        pronto_s1 = 1'b1;
        @(negedge clk);
        pronto_s1 = 1'b0;
      end
    end
  end

  // Scoreboard monitor: every partida pops one expected character.
  initial begin
    fchars[0] = 0; fchars[1] = 0;
    pronto_cnt[0] = 0; pronto_cnt[1] = 0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (reset) begin
          fchars[k] = 0;
        end else begin
          if (partida[k]) begin
            logic [6:0] e;
            int         sz_q;
            sz_q = (k == 0) ? exp_q0.size() : exp_q1.size();
            if (sz_q == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL unexpected_partida u%0d: got char %h, expected none", k, dados[k]);
            end else begin
              if (k == 0) e = exp_q0.pop_front();
              else        e = exp_q1.pop_front();
              chk($sformatf("char u%0d #%0d", k, fchars[k]), 16'(dados[k]), 16'(e));
            end
            fchars[k]++;
          end
          if (pronto[k]) begin
            pronto_cnt[k]++;
            chk($sformatf("frame_len u%0d", k), 16'(fchars[k]), 16'd8);
            fchars[k] = 0;
          end
        end
      end
    end
  end

  // Issue a frame request on instance k and queue the first n expected chars.
  task automatic send(input int k, input logic [15:0] a, input logic [15:0] d,
                      input logic s, input logic [55:0] ec, input int n);
    for (int i = 0; i < n; i++) begin
      if (k == 0) exp_q0.push_back(7'(ec >> (7 * (7 - i))));
      else        exp_q1.push_back(7'(ec >> (7 * (7 - i))));
    end
    if (k == 0) begin ang0 = a[11:0]; dist0 = d[11:0]; end
    else        begin ang1 = a[7:0];  dist1 = d; end
    sz[k]     = s;
    enviar[k] = 1'b1;
    @(posedge clk); #1;
    enviar[k] = 1'b0;
    chk("state_carrega", 16'(db[k]), 16'd1);
    @(posedge clk); #1;
    chk("partida_latency", 16'(partida[k]), 16'd1);
  endtask

  // Bounded wait for the frame-complete pulse.
  task automatic wait_pronto(input int k);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (pronto[k]) begin seen = 1'b1; break; end
    end
    chk($sformatf("pronto_seen u%0d", k), 16'(seen), 16'd1);
    @(posedge clk); #1;
    chk("back_to_idle", 16'(db[k]), 16'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int pc;
    bit hit;
    reset = 1'b1; stray0 = 1'b0;
    enviar[0] = 1'b0; enviar[1] = 1'b0; sz[0] = 1'b0; sz[1] = 1'b0;
    ang0 = '0; dist0 = '0; ang1 = '0; dist1 = '0;
    repeat (3) @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_estado", 16'(db[k]), 16'd0);
      chk("rst_partida", 16'(partida[k]), 16'd0);
      chk("rst_dados", 16'(dados[k]), 16'h00);
      chk("rst_ocupado", 16'(ocupado[k]), 16'd0);
      chk("rst_pronto", 16'(pronto[k]), 16'd0);
    end
    reset = 1'b0;
    @(posedge clk); #1;

    send(0, 16'h045, 16'h123, 1'b0,
         {7'h30, 7'h34, 7'h35, 7'h2C, 7'h31, 7'h32, 7'h33, 7'h23}, 8);
    wait_pronto(0);

    send(0, 16'h000, 16'h007, 1'b1,
         {7'h20, 7'h20, 7'h30, 7'h2C, 7'h20, 7'h20, 7'h37, 7'h23}, 8);
    wait_pronto(0);

    send(0, 16'h0A5, 16'h100, 1'b1,
         {7'h20, 7'h3F, 7'h35, 7'h2C, 7'h31, 7'h30, 7'h30, 7'h23}, 8);
    wait_pronto(0);

    // Mid-frame interference: re-request, changed inputs, stray pronto.
    stray0 = 1'b1;
    send(0, 16'h999, 16'h080, 1'b1,
         {7'h39, 7'h39, 7'h39, 7'h2C, 7'h20, 7'h38, 7'h30, 7'h23}, 8);
    repeat (4) @(posedge clk); #1;
    enviar[0] = 1'b1; ang0 = 12'h111; dist0 = 12'h222; sz[0] = 1'b0;
    repeat (6) @(posedge clk); #1;
    enviar[0] = 1'b0;
    wait_pronto(0);
    stray0 = 1'b0;
    repeat (10) @(posedge clk); #1;
    chk("no_extra_frame", 16'(db[0]), 16'd0);
    chk("queue_empty", 16'(exp_q0.size()), 16'd0);

    // Reset during ESPERA of character 4.
    pc = pronto_cnt[0];
    send(0, 16'h321, 16'h456, 1'b0,
         {7'h33, 7'h32, 7'h31, 7'h2C, 7'h34, 7'h00, 7'h00, 7'h00}, 5);
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (fchars[0] == 5 && db[0] == 4'd3) begin hit = 1'b1; break; end
    end
    chk("reached_espera4", 16'(hit), 16'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_estado", 16'(db[0]), 16'd0);
    chk("abort_partida", 16'(partida[0]), 16'd0);
    chk("abort_dados", 16'(dados[0]), 16'h00);
    chk("abort_ocupado", 16'(ocupado[0]), 16'd0);
    chk("abort_pronto", 16'(pronto[0]), 16'd0);
    reset = 1'b0;
    repeat (20) @(posedge clk); #1;
    chk("abort_no_pronto", 16'(pronto_cnt[0]), 16'(pc));
    chk("abort_queue", 16'(exp_q0.size()), 16'd0);

    send(0, 16'h045, 16'h123, 1'b0,
         {7'h30, 7'h34, 7'h35, 7'h2C, 7'h31, 7'h32, 7'h33, 7'h23}, 8);
    wait_pronto(0);

    // Alternate field widths.
    send(1, 16'h90, 16'h0150, 1'b0,
         {7'h39, 7'h30, 7'h2C, 7'h30, 7'h31, 7'h35, 7'h30, 7'h23}, 8);
    wait_pronto(1);
    send(1, 16'h00, 16'h0150, 1'b1,
         {7'h20, 7'h30, 7'h2C, 7'h20, 7'h31, 7'h35, 7'h30, 7'h23}, 8);
    wait_pronto(1);
    chk("queue1_empty", 16'(exp_q1.size()), 16'd0);

    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
